// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg -- shared types and constants for the shift-and-add multiplier
// sequencer (mul_seq_ctrl and its shift counter mul_seq_cnt).
//   mul_seq_state_t   : FSM state encoding
//   mul_seq_out_t     : bundle of the registered Moore strobes
//   MUL_SEQ_WIDTH_DEF : default number of multiplier bits per operation
//   cnt_bits()        : width of the shift counter for a given WIDTH
//   decode_outputs()  : Moore decode of the strobes from a state

package mul_seq_pkg;

  localparam int MUL_SEQ_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } mul_seq_state_t;

  typedef struct packed {
    logic ld_en;
    logic acc_clr;
    logic shr_en;
    logic busy;
    logic done;
  } mul_seq_out_t;

  // The counter must be able to hold the value WIDTH itself (final count).
  function automatic int cnt_bits(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int MUL_SEQ_CNT_W_DEF = cnt_bits(MUL_SEQ_WIDTH_DEF);

  // Strobe pattern that belongs to a given state; anything unknown is quiet.
  function automatic mul_seq_out_t decode_outputs(input mul_seq_state_t st);
    mul_seq_out_t o;
    o = '0;
    case (st)
      IDLE:  o = '0;
      LOAD:  begin
        o.ld_en   = 1'b1;
        o.acc_clr = 1'b1;
        o.busy    = 1'b1;
      end
      EVAL:  o.busy = 1'b1;
      SHIFT: begin
        o.shr_en = 1'b1;
        o.busy   = 1'b1;
      end
      DONE:  o.done = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mul_seq_cnt.sv
// mul_seq_cnt -- shift counter for mul_seq_ctrl.
//   clk, reset : clock, synchronous active-high reset
//   clr        : clear the count to zero (LOAD)
//   inc        : count one completed shift (SHIFT)
//   cnt        : number of shifts completed in the current operation
//   tc         : terminal count, high while cnt == WIDTH-1

module mul_seq_cnt
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = MUL_SEQ_WIDTH_DEF,
  parameter int CNT_W = cnt_bits(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(WIDTH);

  logic [CNT_W-1:0] cnt_r;

  // Shift count register; saturates at WIDTH so it can never run past it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (inc && (cnt_r != FULL_C)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;
  assign tc  = (cnt_r == LAST_C);

endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl -- control FSM for a sequential shift-and-add multiplier.
// Drives an external multiplier shift register and accumulator.
//   clk, reset : clock, synchronous active-high reset
//   start      : begin one multiply sequence (only honoured in IDLE)
//   q_lsb      : LSB of the external multiplier shift register
//   q_zero     : external multiplier shift register is all zero
//   ld_en      : parallel-load strobe to the shift register
//   acc_clr    : clear strobe to the accumulator
//   add_en     : accumulate this cycle (EVAL only, follows q_lsb)
//   shr_en     : shift-right strobe to shift register / accumulator
//   busy       : high from LOAD through the last SHIFT
//   done       : one-cycle completion pulse
//   cnt        : shifts completed in the current operation
// Optional build macro MUL_SEQ_EARLY_TERM_EN: when defined, EVAL with
// q_zero=1 finishes the operation immediately (no more adds or shifts).

module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = MUL_SEQ_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         q_lsb,
  input  logic                         q_zero,
  output logic                         ld_en,
  output logic                         acc_clr,
  output logic                         add_en,
  output logic                         shr_en,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(WIDTH+1)-1:0]   cnt
);

  localparam int CNT_W = cnt_bits(WIDTH);

  mul_seq_state_t   state_r;
  mul_seq_out_t     outs_r;
  logic             cnt_clr_s;
  logic             cnt_inc_s;
  logic             cnt_tc_s;
  logic             early_exit_s;
  logic             add_en_s;
  logic [CNT_W-1:0] cnt_s;

`ifdef MUL_SEQ_EARLY_TERM_EN
  assign early_exit_s = q_zero;
`else
  // q_zero stays on the port but plays no part in sequencing.
  logic unused_q_zero_s;
  assign unused_q_zero_s = q_zero;
  assign early_exit_s    = 1'b0;
`endif

  // Next-state rule; shared by the state and output registers so the
  // registered strobes always match the state they accompany.
  function automatic mul_seq_state_t next_state(input mul_seq_state_t st,
                                                input logic start_i,
                                                input logic tc_i,
                                                input logic early_i);
    mul_seq_state_t ns;
    case (st)
      IDLE:    ns = start_i ? LOAD : IDLE;
      LOAD:    ns = EVAL;
      EVAL:    ns = early_i ? DONE : SHIFT;
      SHIFT:   ns = tc_i ? DONE : EVAL;
      DONE:    ns = IDLE;
      default: ns = IDLE;
    endcase
    return ns;
  endfunction

  // Counter control decoded from the current state.
  always_comb begin
    cnt_clr_s = 1'b0;
    cnt_inc_s = 1'b0;
    case (state_r)
      LOAD:    cnt_clr_s = 1'b1;
      SHIFT:   cnt_inc_s = 1'b1;
      default: begin
        cnt_clr_s = 1'b0;
        cnt_inc_s = 1'b0;
      end
    endcase
  end

  // add_en is the one Mealy output: it tracks q_lsb live during EVAL.
  always_comb begin
    add_en_s = 1'b0;
    if (state_r == EVAL) begin
      add_en_s = q_lsb & ~early_exit_s;
    end else begin
      add_en_s = 1'b0;
    end
  end

  // FSM state and registered Moore strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      outs_r  <= '0;
    end else begin
      state_r <= next_state(state_r, start, cnt_tc_s, early_exit_s);
      outs_r  <= decode_outputs(next_state(state_r, start, cnt_tc_s, early_exit_s));
    end
  end

  mul_seq_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr_s),
    .inc   (cnt_inc_s),
    .cnt   (cnt_s),
    .tc    (cnt_tc_s)
  );

  assign ld_en   = outs_r.ld_en;
  assign acc_clr = outs_r.acc_clr;
  assign shr_en  = outs_r.shr_en;
  assign busy    = outs_r.busy;
  assign done    = outs_r.done;
  assign add_en  = add_en_s;
  assign cnt     = cnt_s;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl -- self-checking bench for mul_seq_ctrl (WIDTH=8).
// A small model of the external multiplier shift register feeds q_lsb and
// q_zero. Expected LOAD cycles, add cycles and completion records are pushed
// to queues when start is driven and popped when the DUT produces them.

`timescale 1ns/1ps

module tb_mul_seq_ctrl;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          q_lsb;
  logic          q_zero;
  logic          ld_en;
  logic          acc_clr;
  logic          add_en;
  logic          shr_en;
  logic          busy;
  logic          done;
  logic [CW-1:0] cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    int done_cyc;
    int cnt;
    int shifts;
  } op_exp_t;

  op_exp_t      exp_op_q[$];
  int           exp_ld_q[$];
  int           exp_add_q[$];
  logic [W-1:0] operand;
  logic [W-1:0] mult;
  int           shr_seen;

  mul_seq_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .q_lsb   (q_lsb),
    .q_zero  (q_zero),
    .ld_en   (ld_en),
    .acc_clr (acc_clr),
    .add_en  (add_en),
    .shr_en  (shr_en),
    .busy    (busy),
    .done    (done),
    .cnt     (cnt)
  );

  always #5 clk = ~clk;

  // Cycle number: value during a cycle = rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Shifts an operation performs: all W, or up to the top set bit when the
  // early-termination build is used.
  function automatic int shifts_for(input logic [W-1:0] op);
    int k;
`ifdef MUL_SEQ_EARLY_TERM_EN
    k = 0;
    for (int i = 0; i < W; i++) if (op[i]) k = i + 1;
`else
    k = W;
`endif
    return k;
  endfunction

  // start sampled in cycle c: LOAD at c+1, EVAL i at c+2+2i, DONE after.
  // abort_at > 0 means a reset lands in that cycle: no completion expected.
  function automatic int plan_op(input int c, input logic [W-1:0] op, input int abort_at);
    int k;
    int d;
    op_exp_t e;
    k = shifts_for(op);
    d = (k < W) ? (c + 3 + 2 * k) : (c + 2 + 2 * W);
    exp_ld_q.push_back(c + 1);
    for (int i = 0; i < k; i++) begin
      if (op[i] && (abort_at == 0 || (c + 2 + 2 * i) < abort_at)) exp_add_q.push_back(c + 2 + 2 * i);
    end
    if (abort_at == 0) begin
      e.done_cyc = d;
      e.cnt      = k;
      e.shifts   = k;
      exp_op_q.push_back(e);
    end
    return d;
  endfunction

  // Monitor and shift-register model, both on the falling edge.
  initial begin
    q_lsb    = 1'b0;
    q_zero   = 1'b1;
    mult     = '0;
    shr_seen = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        assert ($onehot0({ld_en, add_en, shr_en}))
          else $error("FAIL strobe_mutex: ld=%b add=%b shr=%b", ld_en, add_en, shr_en);
        assert (!(busy && done)) else $error("FAIL busy_done_overlap");
        assert (int'(cnt) <= W) else $error("FAIL cnt_range: cnt=%0d", cnt);
        if (ld_en) begin
          if (exp_ld_q.size() == 0) check_val("ld_unexpected", 32'(cyc), 32'hFFFF_FFFF);
          else check_val("ld_cycle", 32'(cyc), 32'(exp_ld_q.pop_front()));
          check_val("acc_clr_with_ld", 32'(acc_clr), 32'd1);
          shr_seen = 0;
        end
        if (add_en) begin
          if (exp_add_q.size() == 0) check_val("add_unexpected", 32'(cyc), 32'hFFFF_FFFF);
          else check_val("add_cycle", 32'(cyc), 32'(exp_add_q.pop_front()));
        end
        if (shr_en) shr_seen++;
        if (done) begin
          if (exp_op_q.size() == 0) begin
            check_val("done_unexpected", 32'(cyc), 32'hFFFF_FFFF);
          end else begin
            op_exp_t e;
            e = exp_op_q.pop_front();
            check_val("done_cycle", 32'(cyc), 32'(e.done_cyc));
            check_val("done_cnt", 32'(cnt), 32'(e.cnt));
            check_val("done_shifts", 32'(shr_seen), 32'(e.shifts));
            check_val("done_busy_low", 32'(busy), 32'd0);
          end
        end
        if (ld_en) mult = operand;
        else if (shr_en) mult = mult >> 1;
        q_lsb  = mult[0];
        q_zero = (mult == '0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for every pending expectation to be consumed.
  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_op_q.size() + exp_ld_q.size() + exp_add_q.size()) != 0 && n < budget) begin
      tick();
      n++;
    end
    check_val("queues_drained", 32'(exp_op_q.size() + exp_ld_q.size() + exp_add_q.size()), 32'd0);
    if (n >= budget) begin
      exp_op_q.delete();
      exp_ld_q.delete();
      exp_add_q.delete();
    end
    tick();
  endtask

  task automatic run_single(input logic [W-1:0] op);
    int c;
    int d;
    operand = op;
    c = cyc;
    start = 1'b1;
    d = plan_op(c, op, 0);
    tick();
    start = 1'b0;
    wait_drain(4 * W + 10);
    check_val("cnt_hold_idle", 32'(cnt), 32'(shifts_for(op)));
    check_val("idle_quiet", 32'({ld_en, acc_clr, add_en, shr_en, busy, done}), 32'd0);
    if (d <= c) check_val("plan_order", 32'(d), 32'(c + 1));
  endtask

  initial begin
    int c;
    int acc;
    int d1;
    logic [W-1:0] pats [6];

    reset   = 1'b1;
    start   = 1'b0;
    operand = '0;
    repeat (3) tick();
    check_val("rst_outputs", 32'({ld_en, acc_clr, add_en, shr_en, busy, done}), 32'd0);
    check_val("rst_cnt", 32'(cnt), 32'd0);
    start = 1'b1;
    tick();
    check_val("rst_beats_start", 32'({ld_en, acc_clr, add_en, shr_en, busy, done}), 32'd0);
    start  = 1'b0;
    reset  = 1'b0;
    mon_en = 1'b1;
    tick();

    // Reference pattern 1010_0101: adds at EVAL cycles 2, 6, 12, 16.
    run_single(8'hA5);

    pats[0] = 8'h00; pats[1] = 8'hFF; pats[2] = 8'h80;
    pats[3] = 8'h03; pats[4] = 8'h5A; pats[5] = W'($urandom_range(255, 0));
    foreach (pats[i]) run_single(pats[i]);

    // start held for 40 cycles: back-to-back operations, one IDLE between.
    operand = 8'h80;
    c   = cyc;
    acc = c;
    d1  = plan_op(acc, operand, 0);
    acc = d1 + 1;
    while (acc <= c + 39) acc = plan_op(acc, operand, 0) + 1;
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (cyc == d1 + 1) check_val("b2b_idle_gap", 32'({busy, ld_en, done}), 32'd0);
    end
    start = 1'b0;
    wait_drain(8 * W + 20);

    // Extra start pulses during a running operation are ignored.
    operand = 8'hC3;
    c = cyc;
    start = 1'b1;
    d1 = plan_op(c, operand, 0);
    tick();
    while (cyc <= c + 10) begin
      start = (cyc >= c + 3) ? 1'b1 : 1'b0;
      tick();
    end
    start = 1'b0;
    wait_drain(4 * W + 10);

    // Reset in cycle 9 aborts the operation; a start at cycle 12 restarts.
    operand = 8'hFF;
    c = cyc;
    start = 1'b1;
    d1 = plan_op(c, operand, c + 9);
    tick();
    start = 1'b0;
    while (cyc < c + 9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("abort_outputs", 32'({ld_en, acc_clr, add_en, shr_en, busy, done}), 32'd0);
    check_val("abort_cnt", 32'(cnt), 32'd0);
    while (cyc < c + 12) tick();
    start = 1'b1;
    d1 = plan_op(c + 12, operand, 0);
    tick();
    start = 1'b0;
    check_val("restart_ld", 32'(ld_en), 32'd1);
    wait_drain(4 * W + 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case the stimulus itself wedges.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/mul_seq_ctrl.md
MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 8, number of multiplier bits (shift steps) per operation; legal range 2..32.
REQ-002 Port clk SHALL be: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port reset SHALL be: reset  input  1  synchronous, active-high reset.
REQ-004 Port start SHALL be: start  input  1  request to begin one multiply sequence.
REQ-005 Port q_lsb SHALL be: q_lsb  input  1  current LSB of the external multiplier shift register.
REQ-006 Port q_zero SHALL be: q_zero  input  1  high when the external multiplier shift register is all zero.
REQ-007 Port ld_en SHALL be: ld_en  output  1  parallel-load strobe to the multiplier shift register.
REQ-008 Port acc_clr SHALL be: acc_clr  output  1  clear strobe to the external accumulator.
REQ-009 Port add_en SHALL be: add_en  output  1  accumulate multiplicand into the accumulator this cycle.
REQ-010 Port shr_en SHALL be: shr_en  output  1  shift-right strobe to the shift register and accumulator pair.
REQ-011 Port busy SHALL be: busy  output  1  high from LOAD through the last SHIFT inclusive.
REQ-012 Port done SHALL be: done  output  1  one-cycle completion pulse.
REQ-013 Port cnt SHALL be: cnt  output  $clog2(WIDTH+1)  number of shifts completed in the current operation.

Function
REQ-014 The FSM SHALL have the states IDLE, LOAD, EVAL, SHIFT and DONE, and all outputs SHALL be Moore-decoded from the state register and cnt, except add_en.
- IDLE: all strobes low; start=1 -> LOAD; otherwise stay.
- LOAD: ld_en=1, acc_clr=1, busy=1, cnt<=0; unconditional -> EVAL.
- EVAL: add_en=q_lsb (the only Mealy output), busy=1; unconditional -> SHIFT, except as in REQ-026.
- SHIFT: shr_en=1, busy=1, cnt<=cnt+1; if cnt==WIDTH-1 -> DONE, else -> EVAL.
- DONE: done=1, busy=0; unconditional -> IDLE.
REQ-015 When start is sampled high in IDLE at edge k, LOAD SHALL occupy cycle k+1, EVAL/SHIFT pairs SHALL occupy cycles k+2 .. k+1+2*WIDTH, and DONE SHALL occupy cycle k+2+2*WIDTH.
REQ-016 With WIDTH=8, the latency from start to done SHALL therefore be 18 cycles.
REQ-017 At most one of ld_en, add_en and shr_en SHALL be high in any cycle.
REQ-018 start SHALL be ignored in every state except IDLE; no request is queued.
REQ-019 start held high continuously SHALL produce back-to-back operations, with each DONE followed by exactly one IDLE cycle before the next LOAD.
REQ-020 cnt SHALL hold its final value (WIDTH, or the early-exit value) through DONE and IDLE until the next LOAD clears it.
REQ-021 cnt SHALL never exceed WIDTH.
REQ-022 add_en SHALL follow q_lsb combinationally only while the state is EVAL, and SHALL be 0 in every other state.

Reset
REQ-023 reset=1 at a rising edge SHALL force the state to IDLE and cnt to 0, taking precedence over start.
REQ-024 During and immediately after reset, ld_en, acc_clr, add_en, shr_en, busy and done SHALL all be 0.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no done pulse, and the next start SHALL begin a fresh sequence from LOAD.

Configuration
REQ-026 With macro MUL_SEQ_EARLY_TERM_EN defined, EVAL with q_zero=1 SHALL go directly to DONE with add_en=0 and no further shifts, and cnt SHALL keep the count of shifts completed.
REQ-027 With MUL_SEQ_EARLY_TERM_EN undefined, q_zero SHALL be ignored (port still present), and every operation SHALL take exactly WIDTH shifts.

Structure
REQ-028 Package mul_seq_pkg SHALL hold the state enum typedef (mul_seq_state_t), the default WIDTH constant and the count-width function/localparam.
REQ-029 One sub-module, mul_seq_cnt, SHALL implement the shift counter (clear, increment, terminal-count flag at WIDTH-1); the FSM SHALL stay in mul_seq_ctrl.

Verification
REQ-030 Scenario: WIDTH=8, macro off, one start pulse, q_lsb driven from a model register loaded with 8'b1010_0101 -> ld_en at cycle 1; add_en high in EVAL cycles 2, 6, 12, 16; 8 shr_en pulses; done at cycle 18; cnt=8.
REQ-031 Scenario: start held high for 40 cycles -> two complete operations, with done at cycles 18 and 37, and one IDLE cycle between them.
REQ-032 Scenario: reset asserted at cycle 9 of an operation -> all outputs 0 at the next cycle, no done pulse, and a start at cycle 12 gives ld_en at cycle 13.
REQ-033 Scenario: start pulsed again in cycles 3..10 of a running operation -> no effect; done still at cycle 18 and no extra LOAD.
REQ-034 Scenario: macro on, multiplier 8'b0000_0011 (q_zero rising after 2 shifts) -> DONE at cycle 7, cnt=2, exactly 2 add_en and 2 shr_en pulses.
REQ-035 Scenario: every run, checked by assertion -> ld_en, add_en and shr_en are never simultaneously high, and busy and done are never both high.
